// File: rtl/dmem_responder.sv
// Data-memory responder: in-order request FIFO feeding a fixed-latency
// service FSM over a word-addressed backing store.
module dmem_responder #(
  parameter int QDEPTH    = 4,
  parameter int LATENCY   = 2,
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        rw_in,
  input  logic [3:0]  id_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic [3:0]  id_out,
  output logic        ready_out,
  output logic        stall_out
);

  localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [ADDR_BITS-1:0] fifo_idx  [QDEPTH];
  logic [31:0]          fifo_data [QDEPTH];
  logic                 fifo_rw   [QDEPTH];
  logic [3:0]           fifo_id   [QDEPTH];
  logic [31:0]          mem       [MEM_WORDS];

  logic [CNTW-1:0]      count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] w_idx_q, w_idx_d;
  logic [31:0]          w_data_q, w_data_d;
  logic                 w_rw_q, w_rw_d;
  logic [3:0]           w_id_q, w_id_d;
  logic [31:0]          data_out_q, data_out_d;
  logic [3:0]           id_out_q, id_out_d;
  logic                 ready_q, ready_d;

  logic                 push;
  logic                 pop;
  logic                 mem_we;
  logic                 unused_addr_bits;

  // Only the word-index bits select storage; everything else aliases.
  assign unused_addr_bits = ^{addr_in[31:ADDR_BITS+2], addr_in[1:0]};

  assign stall_out = (count_q == CNTW'(QDEPTH));
  assign data_out  = data_out_q;
  assign id_out    = id_out_q;
  assign ready_out = ready_q;

  always_comb begin
    push       = valid_in && !stall_out;
    pop        = (state_q == ST_IDLE) && (count_q != '0);
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_idx_d    = w_idx_q;
    w_data_d   = w_data_q;
    w_rw_d     = w_rw_q;
    w_id_d     = w_id_q;
    data_out_d = data_out_q;
    id_out_d   = id_out_q;
    ready_d    = 1'b0;
    mem_we     = 1'b0;

    if (state_q == ST_IDLE) begin
      if (pop) begin
        w_idx_d  = fifo_idx[rd_ptr_q];
        w_data_d = fifo_data[rd_ptr_q];
        w_rw_d   = fifo_rw[rd_ptr_q];
        w_id_d   = fifo_id[rd_ptr_q];
        cnt_d    = CW'(LATENCY - 1);
        state_d  = ST_WAIT;
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        // A load sees the array as it was before this edge's write.
        if (w_rw_q) begin
          mem_we     = 1'b1;
          data_out_d = w_data_q;
        end else begin
          data_out_d = mem[w_idx_q];
        end
        id_out_d = w_id_q;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end
    end

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      w_idx_q    <= '0;
      w_data_q   <= '0;
      w_rw_q     <= 1'b0;
      w_id_q     <= '0;
      data_out_q <= '0;
      id_out_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_idx_q    <= w_idx_d;
      w_data_q   <= w_data_d;
      w_rw_q     <= w_rw_d;
      w_id_q     <= w_id_d;
      data_out_q <= data_out_d;
      id_out_q   <= id_out_d;
      ready_q    <= ready_d;
    end
  end

  // Storage arrays carry no reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr_q]  <= addr_in[ADDR_BITS+1:2];
      fifo_data[wr_ptr_q] <= data_in;
      fifo_rw[wr_ptr_q]   <= rw_in;
      fifo_id[wr_ptr_q]   <= id_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[w_idx_q] <= w_data_q;
    end
  end

endmodule
